decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Registered, parametrised successor to the combinational decoder_controller. It sits between fetch and execute in the planned pipelined core. It accepts an instruction word plus PC over a valid/ready handshake, decodes the full RV32I base set, and generates the sign-extended immediate. It adds FENCE/ECALL/EBREAK decode and illegal-instruction detection. A one-entry skid buffer keeps in_ready registered, and a flush input supports branch redirect.

Parameters:
XLEN, 32, datapath width for imm and pc (32 or 64; immediates sign-extend to XLEN)
ENABLE_SYSTEM, 1, 1 = decode FENCE (0001111) and SYSTEM (1110011); 0 = treat both as illegal
STRICT_FUNCT7, 1, 1 = flag OP/shift instructions with a non-canonical funct7 as illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  drop all held and incoming instructions this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept; registered, equals !skid_full
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts the bundle
out_pc  out  XLEN  PC of the decoded instruction
out_rd / out_rs1 / out_rs2  out  5 each  register indices (rd forced 0 when reg_write=0)
out_imm  out  XLEN  I/S/B/U/J immediate, sign-extended
out_reg_write  out  1  register file write enable
out_wb_sel  out  3  000 ALU, 001 MEM, 010 PC+4, 011 IMM, 100 ALU(AUIPC)
out_alu_src  out  1  ALU B operand: 1 = imm
out_alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
out_use_pc_as_alu_a  out  1  ALU A operand = pc
out_mem_read / out_mem_write  out  1 each  memory access enables
out_branch / out_jump / out_jalr  out  1 each  control-flow class
out_funct3  out  3  passed through for ALU, branch and load/store width
out_illegal  out  1  illegal instruction; all other controls are forced safe
out_is_fence / out_is_ecall / out_is_ebreak  out  1 each  system class flags

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): out_valid=0, in_ready=1, skid empty, and all out_* data and control = 0.
- Latency is one cycle: an instruction accepted at edge N shows out_valid=1 after edge N.
- Accept condition: in_valid && in_ready. Transfer condition: out_valid && out_ready.
- Main output register loads when it is empty or a transfer occurs that cycle. The source is the skid entry if occupied, otherwise the input.
- If an instruction is accepted while the main register is full and no transfer occurs, it goes to the skid entry and in_ready falls next cycle.
- Skid drains into the main register on the next transfer; in_ready rises the cycle after that.
- Order is preserved: skid contents always precede the live input.
- Throughput is 1 instruction/cycle when out_ready is held high.
- out_valid stays asserted and out_* stay stable while out_valid && !out_ready.
- flush=1: next cycle out_valid=0, skid empty, in_ready=1. Any input accepted in the same cycle is discarded. flush takes priority over in_valid and out_ready.
- Control encoding per opcode:
  - OP: regwr, wb 000, alu_op 10
  - OP-IMM: regwr, alu_src, alu_op 11
  - LOAD: regwr, wb 001, alu_src, mem_read
  - STORE: alu_src, mem_write
  - BRANCH: alu_op 01, branch
  - JAL: regwr, wb 010, jump
  - JALR: regwr, wb 010, alu_src, jalr
  - LUI: regwr, wb 011
  - AUIPC: regwr, wb 100, alu_src, use_pc
  - FENCE: is_fence only
  - SYSTEM funct3=000 with imm 0 / 1: is_ecall / is_ebreak
- Illegal (out_illegal=1, every other control 0) when any of the following holds:
  - unknown opcode
  - in_instr[1:0] != 11
  - LOAD funct3 in {011, 110, 111}
  - STORE funct3 > 010
  - BRANCH funct3 in {010, 011}
  - JALR funct3 != 0
  - STRICT_FUNCT7=1 and OP funct7 is not 0000000, or 0100000 with funct3 000/101
  - STRICT_FUNCT7=1 and a shift-immediate has imm[11:5] not 0000000, or 0100000 with funct3 101
  - SYSTEM with any other encoding, or ENABLE_SYSTEM=0 for FENCE/SYSTEM
- Illegal instructions still flow with out_valid=1 so the trap logic can act on them.
- in_instr = 0x00000000 is illegal, since bits[1:0] = 00.

Decomposition:
- Shared package rv_decode_pkg:
  - opcode constants
  - wb_sel and alu_op encodings
  - a packed decode-bundle struct
  - imm-type enum (I/S/B/U/J/NONE)
- One combinational sub-module, rv_decode_comb, maps instr to the bundle plus imm.
- decode_stage_pipe holds only the handshake, main register, skid entry and flush logic.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) with out_ready=1. Next cycle: out_valid=1, rd=1, imm=5, regwr=1, alu_src=1, alu_op=11, illegal=0.
- Back-to-back stream 0x0080A103, 0x0020A223, 0xFE000EE3, 0x123452B7 with out_ready=1:
  - lw: mem_read=1, wb 001, imm=8
  - sw: mem_write=1, rd=0, imm=4
  - beq: branch=1, imm=-4 (all ones except bits[1:0]=00)
  - lui: wb 011, imm=0x12345000
  - one result per cycle throughout
- Backpressure: out_ready=0 for 3 cycles while 2 instructions are offered.
  - First is held stable in the main register, second sits in the skid, in_ready=0.
  - Release out_ready: both emerge in order on consecutive cycles and in_ready returns to 1.
- Illegal encodings: 0xFFFFFFFF, 0x00000000 and 0x4000F0B3 (OP, funct3 111, funct7 0100000) each give illegal=1 with every other control 0.
  - With STRICT_FUNCT7=0, 0x4000F0B3 decodes as a legal R-type.
- Flush with the skid full and in_valid=1: next cycle out_valid=0, in_ready=1, and no flushed instruction ever appears.
- 0x00000073 gives is_ecall=1 and 0x00100073 gives is_ebreak=1. With ENABLE_SYSTEM=0 both give illegal=1. Assert rst mid-stream: all outputs read 0 the following cycle.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions.
// Holds the opcode constants, the write-back select and ALU operation
// encodings, the immediate format enum, the packed decode bundle carried
// through the pipeline, and the helper that assembles a 32-bit immediate.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        WB_ALU   = 3'b000,
        WB_MEM   = 3'b001,
        WB_PC4   = 3'b010,
        WB_IMM   = 3'b011,
        WB_AUIPC = 3'b100
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       reg_write;
        wb_sel_t    wb_sel;
        logic       alu_src;
        alu_op_t    alu_op;
        logic       use_pc_as_alu_a;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
        logic       is_fence;
        logic       is_ecall;
        logic       is_ebreak;
    } decode_bundle_t;

    function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_type_t kind);
        logic [31:0] r;
        case (kind)
            IMM_I:   r = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   r = {instr[31:12], 12'b0};
            IMM_J:   r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side signals of the decode stage.
// slave  : the decode stage (consumes in_*, flush, out_ready; drives the rest)
// master : the surrounding pipeline / testbench
interface decode_stage_pipe_if #(parameter int XLEN = 32);
    import rv_decode_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_reg_write;
    logic [2:0]      out_wb_sel;
    logic            out_alu_src;
    logic [1:0]      out_alu_op;
    logic            out_use_pc_as_alu_a;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_branch;
    logic            out_jump;
    logic            out_jalr;
    logic [2:0]      out_funct3;
    logic            out_illegal;
    logic            out_is_fence;
    logic            out_is_ecall;
    logic            out_is_ebreak;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_reg_write, out_wb_sel, out_alu_src, out_alu_op, out_use_pc_as_alu_a,
               out_mem_read, out_mem_write, out_branch, out_jump, out_jalr, out_funct3,
               out_illegal, out_is_fence, out_is_ecall, out_is_ebreak
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_reg_write, out_wb_sel, out_alu_src, out_alu_op, out_use_pc_as_alu_a,
               out_mem_read, out_mem_write, out_branch, out_jump, out_jalr, out_funct3,
               out_illegal, out_is_fence, out_is_ecall, out_is_ebreak
    );
endinterface

// File: rtl/rv_decode_comb.sv
// Combinational RV32I decoder.
// Ports: instr (32-bit instruction word) -> bundle (control/decode fields),
//        imm (sign-extended immediate, XLEN wide).
// An illegal instruction yields illegal=1 with every control and imm at 0.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ENABLE_SYSTEM = 1,
    parameter int STRICT_FUNCT7 = 1
) (
    input  logic [31:0]     instr,
    output decode_bundle_t  bundle,
    output logic [XLEN-1:0] imm
);
    localparam bit SYS_EN = (ENABLE_SYSTEM != 0);
    localparam bit STRICT = (STRICT_FUNCT7 != 0);

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    decode_bundle_t ctl;
    imm_type_t      kind;
    logic           legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        ctl   = '0;
        kind  = IMM_NONE;
        legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = !STRICT || (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                ctl.reg_write = 1'b1;
                ctl.alu_op    = ALU_RTYPE;
            end
            OPC_OP_IMM: begin
                // Only the shift forms constrain the upper immediate bits.
                case (funct3)
                    3'b001:  legal = !STRICT || (funct7 == 7'b0000000);
                    3'b101:  legal = !STRICT || (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.alu_op    = ALU_ITYPE;
                kind          = IMM_I;
            end
            OPC_LOAD: begin
                legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_MEM;
                ctl.alu_src   = 1'b1;
                ctl.mem_read  = 1'b1;
                kind          = IMM_I;
            end
            OPC_STORE: begin
                legal = (funct3 <= 3'b010);
                ctl.alu_src   = 1'b1;
                ctl.mem_write = 1'b1;
                kind          = IMM_S;
            end
            OPC_BRANCH: begin
                legal = !(funct3 == 3'b010 || funct3 == 3'b011);
                ctl.alu_op = ALU_BRANCH;
                ctl.branch = 1'b1;
                kind       = IMM_B;
            end
            OPC_JAL: begin
                legal = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_PC4;
                ctl.jump      = 1'b1;
                kind          = IMM_J;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_PC4;
                ctl.alu_src   = 1'b1;
                ctl.jalr      = 1'b1;
                kind          = IMM_I;
            end
            OPC_LUI: begin
                legal = 1'b1;
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = WB_IMM;
                kind          = IMM_U;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                ctl.reg_write       = 1'b1;
                ctl.wb_sel          = WB_AUIPC;
                ctl.alu_src         = 1'b1;
                ctl.use_pc_as_alu_a = 1'b1;
                kind                = IMM_U;
            end
            OPC_FENCE: begin
                legal = SYS_EN;
                ctl.is_fence = 1'b1;
            end
            OPC_SYSTEM: begin
                legal = SYS_EN && (funct3 == 3'b000) &&
                        (instr[31:20] == 12'd0 || instr[31:20] == 12'd1);
                ctl.is_ecall  = (instr[31:20] == 12'd0);
                ctl.is_ebreak = (instr[31:20] == 12'd1);
            end
            default: legal = 1'b0;
        endcase
        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        bundle = ctl;
        if (!legal) begin
            bundle         = '0;
            bundle.illegal = 1'b1;
        end
        bundle.rd     = bundle.reg_write ? instr[11:7] : 5'd0;
        bundle.rs1    = instr[19:15];
        bundle.rs2    = instr[24:20];
        bundle.funct3 = funct3;
        imm = legal ? XLEN'($signed(imm32(instr, kind))) : '0;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage with a one-entry skid buffer.
// Ports: clk, rst (synchronous, active high), bus (decode_stage_pipe_if.slave):
//   fetch side  flush / in_valid / in_ready / in_instr / in_pc
//   exec side   out_valid / out_ready / out_* decoded bundle, pc and imm
// Decoding happens before the registers, so both the main register and the
// skid entry hold fully decoded bundles.
module decode_stage_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ENABLE_SYSTEM = 1,
    parameter int STRICT_FUNCT7 = 1
) (
    input logic                 clk,
    input logic                 rst,
    decode_stage_pipe_if.slave  bus
);
    decode_bundle_t  dec_bundle;
    logic [XLEN-1:0] dec_imm;

    rv_decode_comb #(
        .XLEN          (XLEN),
        .ENABLE_SYSTEM (ENABLE_SYSTEM),
        .STRICT_FUNCT7 (STRICT_FUNCT7)
    ) u_decode (
        .instr  (bus.in_instr),
        .bundle (dec_bundle),
        .imm    (dec_imm)
    );

    logic            main_valid;
    decode_bundle_t  main_bundle;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] main_imm;
    logic            skid_full;
    decode_bundle_t  skid_bundle;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_imm;

    logic accept;
    logic xfer;
    logic load_main;

    // in_ready is !skid_full, so nothing is ever accepted while the skid is full.
    assign accept    = bus.in_valid && !skid_full;
    assign xfer      = main_valid && bus.out_ready;
    assign load_main = !main_valid || xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid  <= 1'b0;
            main_bundle <= '0;
            main_pc     <= '0;
            main_imm    <= '0;
            skid_full   <= 1'b0;
            skid_bundle <= '0;
            skid_pc     <= '0;
            skid_imm    <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
        end else if (load_main) begin
            if (skid_full) begin
                main_valid  <= 1'b1;
                main_bundle <= skid_bundle;
                main_pc     <= skid_pc;
                main_imm    <= skid_imm;
                skid_full   <= 1'b0;
            end else if (accept) begin
                main_valid  <= 1'b1;
                main_bundle <= dec_bundle;
                main_pc     <= bus.in_pc;
                main_imm    <= dec_imm;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full   <= 1'b1;
            skid_bundle <= dec_bundle;
            skid_pc     <= bus.in_pc;
            skid_imm    <= dec_imm;
        end
    end

    assign bus.in_ready            = !skid_full;
    assign bus.out_valid           = main_valid;
    assign bus.out_pc              = main_pc;
    assign bus.out_imm             = main_imm;
    assign bus.out_rd              = main_bundle.rd;
    assign bus.out_rs1             = main_bundle.rs1;
    assign bus.out_rs2             = main_bundle.rs2;
    assign bus.out_funct3          = main_bundle.funct3;
    assign bus.out_reg_write       = main_bundle.reg_write;
    assign bus.out_wb_sel          = main_bundle.wb_sel;
    assign bus.out_alu_src         = main_bundle.alu_src;
    assign bus.out_alu_op          = main_bundle.alu_op;
    assign bus.out_use_pc_as_alu_a = main_bundle.use_pc_as_alu_a;
    assign bus.out_mem_read        = main_bundle.mem_read;
    assign bus.out_mem_write       = main_bundle.mem_write;
    assign bus.out_branch          = main_bundle.branch;
    assign bus.out_jump            = main_bundle.jump;
    assign bus.out_jalr            = main_bundle.jalr;
    assign bus.out_illegal         = main_bundle.illegal;
    assign bus.out_is_fence        = main_bundle.is_fence;
    assign bus.out_is_ecall        = main_bundle.is_ecall;
    assign bus.out_is_ebreak       = main_bundle.is_ebreak;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Testbench for decode_stage_pipe. Three instances share one stimulus stream:
// dut_a (defaults), dut_b (STRICT_FUNCT7=0), dut_c (ENABLE_SYSTEM=0).
module tb_decode_stage_pipe;

    typedef struct packed {
        logic        rw;
        logic [2:0]  wb;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic        use_pc;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        jr;
        logic        ill;
        logic        fence;
        logic        ecall;
        logic        ebreak;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ctl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } pkt_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    decode_stage_pipe_if #(.XLEN(32)) ifa ();
    decode_stage_pipe_if #(.XLEN(32)) ifb ();
    decode_stage_pipe_if #(.XLEN(32)) ifc ();

    assign ifb.flush     = ifa.flush;
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_instr  = ifa.in_instr;
    assign ifb.in_pc     = ifa.in_pc;
    assign ifb.out_ready = ifa.out_ready;
    assign ifc.flush     = ifa.flush;
    assign ifc.in_valid  = ifa.in_valid;
    assign ifc.in_instr  = ifa.in_instr;
    assign ifc.in_pc     = ifa.in_pc;
    assign ifc.out_ready = ifa.out_ready;

    decode_stage_pipe #(.XLEN(32), .ENABLE_SYSTEM(1), .STRICT_FUNCT7(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    decode_stage_pipe #(.XLEN(32), .ENABLE_SYSTEM(1), .STRICT_FUNCT7(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    decode_stage_pipe #(.XLEN(32), .ENABLE_SYSTEM(0), .STRICT_FUNCT7(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    ctl_t obs_a, obs_b, obs_c;
    assign obs_a = {ifa.out_reg_write, ifa.out_wb_sel, ifa.out_alu_src, ifa.out_alu_op, ifa.out_use_pc_as_alu_a,
                    ifa.out_mem_read, ifa.out_mem_write, ifa.out_branch, ifa.out_jump, ifa.out_jalr, ifa.out_illegal,
                    ifa.out_is_fence, ifa.out_is_ecall, ifa.out_is_ebreak, ifa.out_rd, ifa.out_imm};
    assign obs_b = {ifb.out_reg_write, ifb.out_wb_sel, ifb.out_alu_src, ifb.out_alu_op, ifb.out_use_pc_as_alu_a,
                    ifb.out_mem_read, ifb.out_mem_write, ifb.out_branch, ifb.out_jump, ifb.out_jalr, ifb.out_illegal,
                    ifb.out_is_fence, ifb.out_is_ecall, ifb.out_is_ebreak, ifb.out_rd, ifb.out_imm};
    assign obs_c = {ifc.out_reg_write, ifc.out_wb_sel, ifc.out_alu_src, ifc.out_alu_op, ifc.out_use_pc_as_alu_a,
                    ifc.out_mem_read, ifc.out_mem_write, ifc.out_branch, ifc.out_jump, ifc.out_jalr, ifc.out_illegal,
                    ifc.out_is_fence, ifc.out_is_ecall, ifc.out_is_ebreak, ifc.out_rd, ifc.out_imm};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder: immediates built arithmetically from the word.
    function automatic ctl_t model(input logic [31:0] ins, input bit strict, input bit sys);
        ctl_t        e;
        bit          ok;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] sx, i_imm, s_imm, b_imm, u_imm, j_imm;
        e  = '0;
        ok = 1'b1;
        f7 = ins[31:25];
        f3 = ins[14:12];
        sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = (i_imm & ~32'h1F) | 32'(ins[11:7]);
        b_imm = (sx & 32'hFFFF_F000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = (sx & 32'hFFF0_0000) | (ins & 32'h000F_F000) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        case (ins[6:0])
            7'h33: begin e.rw = 1; e.alu_op = 2; ok = !strict || f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
            7'h13: begin
                e.rw = 1; e.alu_src = 1; e.alu_op = 3; e.imm = i_imm;
                if (f3 == 1) ok = !strict || f7 == 0;
                if (f3 == 5) ok = !strict || f7 == 0 || f7 == 7'h20;
            end
            7'h03: begin e.rw = 1; e.wb = 1; e.alu_src = 1; e.mr = 1; e.imm = i_imm; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin e.alu_src = 1; e.mw = 1; e.imm = s_imm; ok = (f3 <= 2); end
            7'h63: begin e.alu_op = 1; e.br = 1; e.imm = b_imm; ok = !(f3 == 2 || f3 == 3); end
            7'h6F: begin e.rw = 1; e.wb = 2; e.jp = 1; e.imm = j_imm; end
            7'h67: begin e.rw = 1; e.wb = 2; e.alu_src = 1; e.jr = 1; e.imm = i_imm; ok = (f3 == 0); end
            7'h37: begin e.rw = 1; e.wb = 3; e.imm = u_imm; end
            7'h17: begin e.rw = 1; e.wb = 4; e.alu_src = 1; e.use_pc = 1; e.imm = u_imm; end
            7'h0F: begin e.fence = 1; ok = sys; end
            7'h73: begin
                if (sys && f3 == 0 && ins[31:20] == 0) e.ecall = 1;
                else if (sys && f3 == 0 && ins[31:20] == 1) e.ebreak = 1;
                else ok = 0;
            end
            default: ok = 0;
        endcase
        if (ins[1:0] != 2'b11) ok = 0;
        if (!ok) begin
            e     = '0;
            e.ill = 1;
        end
        if (e.rw) e.rd = ins[11:7];
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0:  w[6:0] = 7'h33;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h6F;
            6:  w[6:0] = 7'h67;
            7:  w[6:0] = 7'h37;
            8:  w[6:0] = 7'h17;
            9:  w[6:0] = 7'h0F;
            10: w[6:0] = 7'h73;
            11: w = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073;
            12: ;
            13: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20; end
            14: begin
                w[6:0]   = 7'h13;
                w[14:12] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
                w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            end
            default: begin w[6:0] = 7'h13; w[31:25] = 7'h00; end
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.flush     = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_instr  = 32'h0;
        ifa.in_pc     = 32'h0;
        ifa.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid); end
        n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", ifa.in_ready); end
        n_cmp++; if (obs_a !== ctl_t'(0)) begin n_bad++; $display("FAIL reset_ctl: got %h expected 0", obs_a); end
        n_cmp++; if ({ifa.out_pc, ifa.out_rs1, ifa.out_rs2, ifa.out_funct3} !== 45'd0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {ifa.out_pc, ifa.out_rs1, ifa.out_rs2, ifa.out_funct3});
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_instr  = 32'h0050_0093;
        ifa.in_pc     = 32'h0000_0100;
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid: got %b expected 1", ifa.out_valid); end
        n_cmp++; if (ifa.out_rd !== 5'd1) begin n_bad++; $display("FAIL addi_rd: got %0d expected 1", ifa.out_rd); end
        n_cmp++; if (ifa.out_imm !== 32'd5) begin n_bad++; $display("FAIL addi_imm: got %h expected 5", ifa.out_imm); end
        n_cmp++; if ({ifa.out_reg_write, ifa.out_alu_src, ifa.out_alu_op, ifa.out_illegal} !== 5'b11110) begin
            n_bad++; $display("FAIL addi_ctl: got %b expected 11110", {ifa.out_reg_write, ifa.out_alu_src, ifa.out_alu_op, ifa.out_illegal});
        end
        n_cmp++; if (ifa.out_pc !== 32'h100) begin n_bad++; $display("FAIL addi_pc: got %h expected 100", ifa.out_pc); end
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_drain: got %b expected 0", ifa.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4];
        logic [31:0] w;
        prog[0] = 32'h0080_A103;
        prog[1] = 32'h0020_A223;
        prog[2] = 32'hFE00_0EE3;
        prog[3] = 32'h1234_52B7;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_instr = prog[i];
            ifa.in_pc    = 32'h200 + 32'(4 * i);
            tick();
            w = prog[i];
            n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.in_ready !== 1'b1) begin
                n_bad++; $display("FAIL b2b_flow%0d: got valid=%b ready=%b expected 1 1", i, ifa.out_valid, ifa.in_ready);
            end
            n_cmp++; if (ifa.out_pc !== 32'h200 + 32'(4 * i)) begin n_bad++; $display("FAIL b2b_pc%0d: got %h", i, ifa.out_pc); end
            n_cmp++; if (obs_a !== model(w, 1, 1)) begin n_bad++; $display("FAIL b2b_model%0d: got %h expected %h", i, obs_a, model(w, 1, 1)); end
            case (i)
                0: begin n_cmp++; if ({ifa.out_mem_read, ifa.out_wb_sel, ifa.out_imm} !== {1'b1, 3'b001, 32'd8}) begin
                       n_bad++; $display("FAIL b2b_lw: got mr=%b wb=%b imm=%h expected 1 001 8", ifa.out_mem_read, ifa.out_wb_sel, ifa.out_imm); end end
                1: begin n_cmp++; if ({ifa.out_mem_write, ifa.out_rd, ifa.out_imm} !== {1'b1, 5'd0, 32'd4}) begin
                       n_bad++; $display("FAIL b2b_sw: got mw=%b rd=%0d imm=%h expected 1 0 4", ifa.out_mem_write, ifa.out_rd, ifa.out_imm); end end
                2: begin n_cmp++; if ({ifa.out_branch, ifa.out_imm} !== {1'b1, 32'hFFFF_FFFC}) begin
                       n_bad++; $display("FAIL b2b_beq: got br=%b imm=%h expected 1 fffffffc", ifa.out_branch, ifa.out_imm); end end
                default: begin n_cmp++; if ({ifa.out_wb_sel, ifa.out_imm} !== {3'b011, 32'h1234_5000}) begin
                       n_bad++; $display("FAIL b2b_lui: got wb=%b imm=%h expected 011 12345000", ifa.out_wb_sel, ifa.out_imm); end end
            endcase
        end
        ifa.in_valid = 1'b0;
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b expected 0", ifa.out_valid); end
    endtask

    task automatic test_backpressure();
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_instr  = 32'h0050_0093;
        ifa.in_pc     = 32'h300;
        tick();
        ifa.in_instr = 32'h1234_52B7;
        ifa.in_pc    = 32'h304;
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_skid_ready: got %b expected 0", ifa.in_ready); end
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== 32'h300 || ifa.out_imm !== 32'd5) begin
            n_bad++; $display("FAIL bp_hold: got valid=%b pc=%h imm=%h expected 1 300 5", ifa.out_valid, ifa.out_pc, ifa.out_imm);
        end
        n_cmp++; if (ifa.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready: got %b expected 0", ifa.in_ready); end
        ifa.out_ready = 1'b1;
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== 32'h304 || ifa.out_imm !== 32'h1234_5000) begin
            n_bad++; $display("FAIL bp_second: got valid=%b pc=%h imm=%h expected 1 304 12345000", ifa.out_valid, ifa.out_pc, ifa.out_imm);
        end
        n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b expected 1", ifa.in_ready); end
        tick();
        n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b expected 0", ifa.out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        ctl_t        exp_ill;
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h0000_0000;
        words[2] = 32'h4000_F0B3;
        exp_ill     = '0;
        exp_ill.ill = 1'b1;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_instr = words[i];
            ifa.in_pc    = 32'h400 + 32'(4 * i);
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b1 || obs_a !== exp_ill) begin
                n_bad++; $display("FAIL illegal%0d: got valid=%b ctl=%h expected 1 %h", i, ifa.out_valid, obs_a, exp_ill);
            end
        end
        n_cmp++; if (obs_b.ill !== 1'b0 || obs_b.rw !== 1'b1 || obs_b.alu_op !== 2'b10 || obs_b.rd !== 5'd1) begin
            n_bad++; $display("FAIL nonstrict_rtype: got ill=%b rw=%b alu_op=%b rd=%0d expected 0 1 10 1", obs_b.ill, obs_b.rw, obs_b.alu_op, obs_b.rd);
        end
        ifa.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_system();
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_instr  = 32'h0000_0073;
        ifa.in_pc     = 32'h500;
        tick();
        ifa.in_instr = 32'h0010_0073;
        ifa.in_pc    = 32'h504;
        n_cmp++; if ({obs_a.ecall, obs_a.ebreak, obs_a.ill} !== 3'b100) begin
            n_bad++; $display("FAIL ecall: got ecall=%b ebreak=%b ill=%b expected 1 0 0", obs_a.ecall, obs_a.ebreak, obs_a.ill);
        end
        n_cmp++; if (obs_c.ill !== 1'b1 || obs_c.ecall !== 1'b0) begin
            n_bad++; $display("FAIL ecall_nosys: got ill=%b ecall=%b expected 1 0", obs_c.ill, obs_c.ecall);
        end
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if ({obs_a.ecall, obs_a.ebreak, obs_a.ill} !== 3'b010) begin
            n_bad++; $display("FAIL ebreak: got ecall=%b ebreak=%b ill=%b expected 0 1 0", obs_a.ecall, obs_a.ebreak, obs_a.ill);
        end
        n_cmp++; if (obs_c.ill !== 1'b1 || obs_c.ebreak !== 1'b0) begin
            n_bad++; $display("FAIL ebreak_nosys: got ill=%b ebreak=%b expected 1 0", obs_c.ill, obs_c.ebreak);
        end
        tick();
    endtask

    task automatic test_flush();
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_instr  = 32'h0050_0093;
        ifa.in_pc     = 32'h600;
        tick();
        ifa.in_pc = 32'h604;
        tick();
        ifa.in_pc = 32'h608;
        ifa.flush = 1'b1;
        tick();
        ifa.flush    = 1'b0;
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_state: got valid=%b ready=%b expected 0 1", ifa.out_valid, ifa.in_ready);
        end
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ifa.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_leak%0d: got valid=%b pc=%h expected 0", i, ifa.out_valid, ifa.out_pc); end
        end
        ifa.in_valid = 1'b1;
        ifa.in_pc    = 32'h700;
        tick();
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== 32'h700) begin
            n_bad++; $display("FAIL flush_resume: got valid=%b pc=%h expected 1 700", ifa.out_valid, ifa.out_pc);
        end
        tick();
    endtask

    task automatic test_random(input int cycles);
        pkt_t        q[$];
        pkt_t        p;
        logic [31:0] w;
        bit          acc, xf;
        int          sz;
        for (int c = 0; c < cycles; c++) begin
            ifa.in_valid  = ($urandom_range(0, 3) != 0);
            ifa.in_instr  = rand_instr();
            ifa.in_pc     = $urandom & 32'hFFFF_FFFC;
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifa.flush     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            sz = q.size();
            n_cmp++; if (ifa.in_ready !== (sz < 2)) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, ifa.in_ready, sz < 2); end
            n_cmp++; if (ifa.out_valid !== (sz > 0)) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, ifa.out_valid, sz > 0); end
            if (sz > 0) begin
                p = q[0];
                w = p.instr;
                n_cmp++; if (obs_a !== model(w, 1, 1)) begin n_bad++; $display("FAIL rnd_ctl_a c%0d i=%h: got %h expected %h", c, w, obs_a, model(w, 1, 1)); end
                n_cmp++; if (obs_b !== model(w, 0, 1)) begin n_bad++; $display("FAIL rnd_ctl_b c%0d i=%h: got %h expected %h", c, w, obs_b, model(w, 0, 1)); end
                n_cmp++; if (obs_c !== model(w, 1, 0)) begin n_bad++; $display("FAIL rnd_ctl_c c%0d i=%h: got %h expected %h", c, w, obs_c, model(w, 1, 0)); end
                n_cmp++; if ({ifa.out_pc, ifa.out_rs1, ifa.out_rs2, ifa.out_funct3} !== {p.pc, w[19:15], w[24:20], w[14:12]}) begin
                    n_bad++; $display("FAIL rnd_data c%0d: got pc=%h rs1=%0d rs2=%0d f3=%0d expected %h %0d %0d %0d",
                                      c, ifa.out_pc, ifa.out_rs1, ifa.out_rs2, ifa.out_funct3, p.pc, w[19:15], w[24:20], w[14:12]);
                end
            end
            if (ifa.flush) begin
                q.delete();
            end else begin
                xf  = (sz > 0) && ifa.out_ready;
                acc = ifa.in_valid && (sz < 2);
                if (xf) void'(q.pop_front());
                if (acc) q.push_back('{instr: ifa.in_instr, pc: ifa.in_pc});
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_instr  = 32'h0080_A103;
        ifa.in_pc     = 32'h800;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.in_valid = 1'b0;
        n_cmp++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_flow: got valid=%b ready=%b expected 0 1", ifa.out_valid, ifa.in_ready);
        end
        n_cmp++; if (obs_a !== ctl_t'(0) || ifa.out_pc !== 32'h0 || ifa.out_rs1 !== 5'd0 || ifa.out_funct3 !== 3'd0) begin
            n_bad++; $display("FAIL midrst_data: got ctl=%h pc=%h expected 0 0", obs_a, ifa.out_pc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_system();
        test_flush();
        test_random(3000);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
